ddr2_odt_ctrl: RTL
==================

DDR2_ODT_CTRL -- requirements
Module: ddr2_odt_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- WL, 3: write latency in clk cycles; legal range 2..15.
- BURST_LEN, 4: burst length; legal values 4 or 8.
- AOND, 2: ODT turn-on lead before write data, in cycles; AOND <= WL-1.
- TAIL, 1: extra ODT hold cycles after the last data beat; legal range 0..4.
REQ-002 Derived constants: ON_DLY = WL-AOND, which is always >= 1; OFF_DLY = WL+BURST_LEN/2+TAIL, which is always <= 31.
REQ-003 Ports, one per line: name, direction, width, meaning:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- cke, in, 1: clock enable mirrored from the pad.
- odt_en, in, 1: Rtt enabled in the mode register.
- cmd_valid, in, 1: upstream command request.
- cmd_is_write, in, 1: request is a WRITE.
- cmd_is_read, in, 1: request is a READ.
- cmd_ready, out, 1: request accepted this cycle.
- odt_out, out, 1: registered ODT pad drive.
- rd_stall, out, 1: a READ is being held off by ODT.
- cmd_err, out, 1: illegal request seen.
- wr_cnt, out, 16: count of accepted WRITEs.
- stall_cnt, out, 16: count of READ stall cycles.

Function
REQ-004 "Accept" means cmd_valid & cmd_ready at a rising clk edge; T0 is the cycle in which a WRITE is accepted.
REQ-005 Write history: an OFF_DLY-bit shift register wr_hist; bit 0 is set on a WRITE accept; the register shifts every cycle.
REQ-006 odt_out is registered. It is high in cycle T iff odt_en & cke & (a WRITE was accepted in some cycle within T-OFF_DLY+1 .. T-ON_DLY).
- With default parameters, one WRITE at T0 gives odt_out high in cycles T0+1 .. T0+5.
REQ-007 Overlapping write windows merge into one continuous ODT assertion with no gap cycle.
REQ-008 WRITE readiness: cmd_ready is 1 for a WRITE whenever cke=1 and the request is legal.
REQ-009 READ readiness: cmd_ready is 1 for a READ iff cke=1 and no WRITE was accepted in cycles T-(OFF_DLY-1) .. T-1.
- This guarantees odt_out=0 in any cycle in which a READ is accepted.
REQ-010 When odt_en=0, READ gating is disabled, odt_out stays 0, and wr_hist still records writes.
REQ-011 rd_stall = cmd_valid & cmd_is_read & ~cmd_ready & cke. It is combinational.
REQ-012 cke=0 forces cmd_ready=0, odt_out=0 from the next edge, and clears wr_hist. No command is accepted while cke=0.
REQ-013 Illegal request: cmd_valid with both cmd_is_read and cmd_is_write set, or with neither set.
- cmd_ready=0 for it; nothing is recorded.
- cmd_err pulses high for one cycle, registered, in the following cycle.
REQ-014 cmd_valid=0 gives cmd_ready=0 and rd_stall=0.
REQ-015 Only one command can be accepted per cycle; no simultaneous read and write acceptance is possible.

Reset
REQ-016 Reset clears wr_hist and drives odt_out=0, cmd_err=0, wr_cnt=0, stall_cnt=0.
REQ-017 Reset asserted mid-window aborts the ODT window: odt_out=0 at the first edge with reset high.
REQ-018 During reset cmd_ready=0. A READ presented in the first cycle after reset releases is ready, provided cke=1.

Configuration
REQ-019 Macro DDR2_ODT_CNT_EN controls the statistics counters.
- Defined: wr_cnt increments on each WRITE accept. stall_cnt increments on each cycle with rd_stall=1. Both counters saturate at 16'hFFFF.
- Undefined: wr_cnt and stall_cnt are constant 0 and no counter flops are built. All other behaviour is unchanged.

Verification
REQ-020 Single WRITE at T0, default parameters -> odt_out=1 in T0+1..T0+5 and 0 in T0+6; wr_cnt=1.
REQ-021 WRITEs at T0 and T0+2 -> odt_out=1 continuously in T0+1..T0+7 and 0 in T0+8.
REQ-022 WRITE at T0, READ held valid from T0+1 -> cmd_ready=0 and rd_stall=1 in T0+1..T0+5; READ accepted in T0+6 with odt_out=0; stall_cnt=5 (CNT_EN defined).
REQ-023 odt_en=0, WRITE at T0, READ at T0+1 -> odt_out stays 0 and the READ is accepted in T0+1.
REQ-024 WRITE at T0, reset high in T0+2 -> odt_out=0 from T0+2; after release, a READ is accepted immediately and counters read 0.
REQ-025 Illegal request (is_read=is_write=1) at T1 -> cmd_ready=0 at T1, cmd_err=1 at T1+1 only. cke=0 with a WRITE valid -> cmd_ready=0 and odt_out=0.

Source files
------------

// File: rtl/ddr2_odt_ctrl.sv
// DDR2 on-die-termination controller: drives ODT around write bursts and holds off READs while ODT may be on.
// Build with DDR2_ODT_CNT_EN defined to get the saturating wr_cnt / stall_cnt statistics counters.
module ddr2_odt_ctrl #(
    parameter int WL        = 3,
    parameter int BURST_LEN = 4,
    parameter int AOND      = 2,
    parameter int TAIL      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cke,
    input  logic        odt_en,
    input  logic        cmd_valid,
    input  logic        cmd_is_write,
    input  logic        cmd_is_read,
    output logic        cmd_ready,
    output logic        odt_out,
    output logic        rd_stall,
    output logic        cmd_err,
    output logic [15:0] wr_cnt,
    output logic [15:0] stall_cnt
);

    localparam int ON_DLY  = WL - AOND;
    localparam int OFF_DLY = WL + BURST_LEN / 2 + TAIL;

    function automatic logic [OFF_DLY:0] range_mask(input int lo, input int hi);
        logic [OFF_DLY:0] m;
        for (int j = 0; j <= OFF_DLY; j++) begin
            m[j] = (j >= lo) && (j <= hi);
        end
        return m;
    endfunction

    // Extended history: bit 0 is this cycle's accept, bit j a WRITE accepted j cycles ago.
    // The registered ODT for the next cycle covers writes ON_DLY..OFF_DLY-1 cycles before it.
    localparam logic [OFF_DLY:0] ODT_MASK = range_mask(ON_DLY - 1, OFF_DLY - 2);
    localparam logic [OFF_DLY:0] RD_MASK  = range_mask(0, OFF_DLY - 2);

    logic [OFF_DLY-1:0] r_wr_hist;
    logic               r_odt;
    logic               r_cmd_err;
    logic               w_legal;
    logic               w_illegal;
    logic               w_rd_block;
    logic               w_wr_acc;
    logic [OFF_DLY:0]   w_hist_ext;
    logic               w_odt_hit;

    // Handshake: a command is taken at a rising edge where cmd_valid & cmd_ready; cmd_ready
    // never depends on itself and is held low during reset, while cke is low, or for illegal requests.
    assign w_legal    = cmd_valid & (cmd_is_write ^ cmd_is_read);
    assign w_illegal  = cmd_valid & ~(cmd_is_write ^ cmd_is_read);
    assign w_rd_block = odt_en & (|(r_wr_hist & RD_MASK[OFF_DLY-1:0]));
    assign cmd_ready  = ~reset & cke & w_legal & (cmd_is_write | ~w_rd_block);
    assign rd_stall   = cmd_valid & cmd_is_read & ~cmd_ready & cke;
    assign w_wr_acc   = cmd_ready & cmd_is_write;
    assign w_hist_ext = {r_wr_hist, w_wr_acc};
    assign w_odt_hit  = |(w_hist_ext & ODT_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_hist <= '0;
            r_odt     <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_illegal;
            if (!cke) begin
                r_wr_hist <= '0;
                r_odt     <= 1'b0;
            end else begin
                r_wr_hist <= {r_wr_hist[OFF_DLY-2:0], w_wr_acc};
                r_odt     <= odt_en & w_odt_hit;
            end
        end
    end

    assign odt_out = r_odt;
    assign cmd_err = r_cmd_err;

`ifdef DDR2_ODT_CNT_EN
    logic [15:0] r_wr_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_wr_acc && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (rd_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign wr_cnt    = r_wr_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign wr_cnt    = 16'd0;
    assign stall_cnt = 16'd0;
`endif

endmodule
